// File: rtl/traffic_analyzer_window_ctrl_if.sv
// traffic_analyzer_window_ctrl_if: CPU-side command and status bundle of the measurement-window sequencer
interface traffic_analyzer_window_ctrl_if #(
    parameter int C_DURATION_WIDTH = 32
);
    logic                        start;
    logic                        abort;
    logic                        immediate;
    logic [47:0]                 start_sec;
    logic [29:0]                 start_nsec;
    logic [C_DURATION_WIDTH-1:0] duration;
    logic                        busy;
    logic                        done;
    logic                        drain_timeout;
    logic                        aborted;
    logic [2:0]                  state;
    logic [C_DURATION_WIDTH-1:0] elapsed;

    modport master (
        output start, abort, immediate, start_sec, start_nsec, duration,
        input  busy, done, drain_timeout, aborted, state, elapsed
    );

    modport slave (
        input  start, abort, immediate, start_sec, start_nsec, duration,
        output busy, done, drain_timeout, aborted, state, elapsed
    );
endinterface

// File: rtl/traffic_analyzer_window_ctrl.sv
// traffic_analyzer_window_ctrl: drives analyzer run/freeze_stats over a time-armed, gap-aligned measurement window
module traffic_analyzer_window_ctrl #(
    parameter int C_DURATION_WIDTH = 32,
    parameter int C_DRAIN_TIMEOUT  = 16384,
    parameter int C_TIMEOUT_WIDTH  = 15
) (
    input  logic                          clk,
    input  logic                          resetn,
    traffic_analyzer_window_ctrl_if.slave ctrl,
    input  logic [47:0]                   sec,
    input  logic [29:0]                   nsec,
    input  logic                          gmii_en,
    output logic                          run,
    output logic                          freeze_stats
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_TIME = 3'd1,
        S_MEASURE   = 3'd2,
        S_DRAIN     = 3'd3,
        S_FROZEN    = 3'd4
    } state_t;

    localparam logic [C_TIMEOUT_WIDTH-1:0] DRAIN_LAST = C_TIMEOUT_WIDTH'(C_DRAIN_TIMEOUT - 1);

    state_t                      state_q, state_d;
    logic [47:0]                 start_sec_q;
    logic [29:0]                 start_nsec_q;
    logic [C_DURATION_WIDTH-1:0] duration_q, elapsed_q;
    logic [C_TIMEOUT_WIDTH-1:0]  drain_cnt_q;
    logic                        busy_q, done_q, aborted_q, drain_timeout_q;
    logic                        take_start, take_abort, timeout_hit, time_reached;
    logic                        run_d, freeze_d, busy_d;

    assign time_reached = {sec, nsec} >= {start_sec_q, start_nsec_q};
    assign take_abort   = ctrl.abort && state_q != S_IDLE;
    assign take_start   = ctrl.start && !ctrl.abort && (state_q == S_IDLE || state_q == S_FROZEN);
    assign timeout_hit  = state_q == S_DRAIN && gmii_en && drain_cnt_q == DRAIN_LAST;

    assign ctrl.busy          = busy_q;
    assign ctrl.done          = done_q;
    assign ctrl.aborted       = aborted_q;
    assign ctrl.drain_timeout = drain_timeout_q;
    assign ctrl.state         = state_q;
    assign ctrl.elapsed       = elapsed_q;

    // next state: abort beats start, start only from IDLE/FROZEN, then per-state progress
    always_comb begin
        state_d = state_q;
        if (take_abort)
            state_d = S_IDLE;
        else if (take_start)
            state_d = !ctrl.immediate ? S_WAIT_TIME : (ctrl.duration == '0 ? S_DRAIN : S_MEASURE);
        else
            case (state_q)
                S_WAIT_TIME: state_d = !time_reached ? S_WAIT_TIME : (duration_q == '0 ? S_DRAIN : S_MEASURE);
                S_MEASURE:   state_d = elapsed_q + C_DURATION_WIDTH'(1) == duration_q ? S_DRAIN : S_MEASURE;
                S_DRAIN:     state_d = (!gmii_en || drain_cnt_q == DRAIN_LAST) ? S_FROZEN : S_DRAIN;
                default:     state_d = state_q;
            endcase
    end

    // output decode of the upcoming state so registered outputs change with the state
    always_comb begin
        run_d    = state_d == S_MEASURE || state_d == S_DRAIN;
        freeze_d = state_d == S_FROZEN;
        busy_d   = state_d == S_WAIT_TIME || run_d;
    end

    // state, window parameters, counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= S_IDLE;
            start_sec_q     <= '0;
            start_nsec_q    <= '0;
            duration_q      <= '0;
            elapsed_q       <= '0;
            drain_cnt_q     <= '0;
            run             <= 1'b0;
            freeze_stats    <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            aborted_q       <= 1'b0;
            drain_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            run             <= run_d;
            freeze_stats    <= freeze_d;
            busy_q          <= busy_d;
            done_q          <= freeze_d;
            aborted_q       <= take_abort;
            drain_timeout_q <= (take_abort || take_start) ? 1'b0 : (timeout_hit ? 1'b1 : drain_timeout_q);
            elapsed_q       <= take_start ? '0 : (state_q == S_MEASURE && !take_abort) ? elapsed_q + C_DURATION_WIDTH'(1) : elapsed_q;
            drain_cnt_q     <= (state_q == S_DRAIN && gmii_en) ? drain_cnt_q + C_TIMEOUT_WIDTH'(1) : '0;
            start_sec_q     <= take_start ? ctrl.start_sec : start_sec_q;
            start_nsec_q    <= take_start ? ctrl.start_nsec : start_nsec_q;
            duration_q      <= take_start ? ctrl.duration : duration_q;
        end
    end
endmodule

// File: tb/tb_traffic_analyzer_window_ctrl.sv
// tb_traffic_analyzer_window_ctrl: vector table, directed corner cases and randomized run against a window model
module tb_traffic_analyzer_window_ctrl;
    localparam int DW       = 32;
    localparam int TMO      = 16;
    localparam int S_IDLE   = 0;
    localparam int S_WAIT   = 1;
    localparam int S_MEAS   = 2;
    localparam int S_DRAIN  = 3;
    localparam int S_FROZEN = 4;

    typedef struct {
        logic          start;
        logic          abort;
        logic          immediate;
        logic          gmii_en;
        logic [DW-1:0] duration;
        int            es, er, ef, eb, ed, ea;
        logic [DW-1:0] ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        gmii_en;
    logic        run;
    logic        freeze_stats;
    int          tests = 0;
    int          fails = 0;
    int          n;
    vec_t        vt[18];

    int            m_state;
    int            m_dn;
    logic [DW-1:0] m_elapsed, m_dur;
    logic          m_aborted, m_dt;
    logic [77:0]   m_t;

    traffic_analyzer_window_ctrl_if #(.C_DURATION_WIDTH(DW)) cif ();

    traffic_analyzer_window_ctrl #(
        .C_DURATION_WIDTH(DW),
        .C_DRAIN_TIMEOUT(TMO),
        .C_TIMEOUT_WIDTH(15)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .ctrl(cif),
        .sec(sec),
        .nsec(nsec),
        .gmii_en(gmii_en),
        .run(run),
        .freeze_stats(freeze_stats)
    );

    // free-running clock
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cif.start = 1'b0;
        cif.abort = 1'b0;
    endtask

    function automatic vec_t mk(input int st, ab, im, du, g, es, er, ef, eb, ed, ea, ee);
        vec_t v;
        v.start     = st[0];
        v.abort     = ab[0];
        v.immediate = im[0];
        v.duration  = du;
        v.gmii_en   = g[0];
        v.es = es; v.er = er; v.ef = ef; v.eb = eb; v.ed = ed; v.ea = ea;
        v.ee = ee;
        return v;
    endfunction

    task automatic chk_val(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int es, er, ef, eb, ed, ea, edt, input logic [DW-1:0] ee);
        logic [40:0] e, a;
        e = {es[2:0], er[0], ef[0], eb[0], ed[0], ea[0], edt[0], ee};
        a = {cif.state, run, freeze_stats, cif.busy, cif.done, cif.aborted, cif.drain_timeout, cif.elapsed};
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got state=%0d run=%0b frz=%0b busy=%0b done=%0b abt=%0b dto=%0b elapsed=%0d expected state=%0d run=%0b frz=%0b busy=%0b done=%0b abt=%0b dto=%0b elapsed=%0d",
                     nm, a[40:38], a[37], a[36], a[35], a[34], a[33], a[32], a[31:0],
                     e[40:38], e[37], e[36], e[35], e[34], e[33], e[32], e[31:0]);
        end
    endtask

    task automatic chk_st(input string nm, input int es, input logic ea, input logic edt, input logic [DW-1:0] ee);
        chk_out(nm, es, int'(es == S_MEAS || es == S_DRAIN), int'(es == S_FROZEN),
                int'(es >= S_WAIT && es <= S_DRAIN), int'(es == S_FROZEN), int'(ea), int'(edt), ee);
    endtask

    task automatic model_step(input logic st, ab, im, input logic [47:0] ss, input logic [29:0] sn,
                              input logic [DW-1:0] du, input logic g, input logic [77:0] now);
        m_aborted = 1'b0;
        if (ab && m_state != S_IDLE) begin
            m_state   = S_IDLE;
            m_aborted = 1'b1;
            m_dt      = 1'b0;
        end else if (st && !ab && (m_state == S_IDLE || m_state == S_FROZEN)) begin
            m_dur     = du;
            m_t       = {ss, sn};
            m_elapsed = '0;
            m_dt      = 1'b0;
            m_dn      = 0;
            m_state   = !im ? S_WAIT : (du == 0 ? S_DRAIN : S_MEAS);
        end else if (m_state == S_WAIT) begin
            if (now >= m_t) begin
                m_state = m_dur == 0 ? S_DRAIN : S_MEAS;
                m_dn    = 0;
            end
        end else if (m_state == S_MEAS) begin
            m_elapsed = m_elapsed + 1;
            if (m_elapsed == m_dur) begin
                m_state = S_DRAIN;
                m_dn    = 0;
            end
        end else if (m_state == S_DRAIN) begin
            m_dn++;
            if (!g)
                m_state = S_FROZEN;
            else if (m_dn == TMO) begin
                m_state = S_FROZEN;
                m_dt    = 1'b1;
            end
        end
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        cif.immediate  = 1'b0;
        cif.start_sec  = '0;
        cif.start_nsec = '0;
        cif.duration   = '0;
        sec     = '0;
        nsec    = '0;
        gmii_en = 1'b0;
        vt[0]  = mk(1, 0, 1, 3, 0, S_MEAS,   1, 0, 1, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 3, 0, S_MEAS,   1, 0, 1, 0, 0, 1);
        vt[2]  = mk(0, 0, 1, 3, 0, S_MEAS,   1, 0, 1, 0, 0, 2);
        vt[3]  = mk(0, 0, 1, 3, 0, S_DRAIN,  1, 0, 1, 0, 0, 3);
        vt[4]  = mk(0, 0, 1, 3, 0, S_FROZEN, 0, 1, 0, 1, 0, 3);
        vt[5]  = mk(1, 0, 1, 0, 0, S_DRAIN,  1, 0, 1, 0, 0, 0);
        vt[6]  = mk(0, 0, 1, 0, 1, S_DRAIN,  1, 0, 1, 0, 0, 0);
        vt[7]  = mk(0, 0, 1, 0, 0, S_FROZEN, 0, 1, 0, 1, 0, 0);
        vt[8]  = mk(0, 1, 1, 0, 0, S_IDLE,   0, 0, 0, 0, 1, 0);
        vt[9]  = mk(0, 0, 1, 0, 0, S_IDLE,   0, 0, 0, 0, 0, 0);
        vt[10] = mk(0, 1, 1, 0, 0, S_IDLE,   0, 0, 0, 0, 0, 0);
        vt[11] = mk(1, 0, 1, 5, 0, S_MEAS,   1, 0, 1, 0, 0, 0);
        vt[12] = mk(1, 0, 1, 2, 0, S_MEAS,   1, 0, 1, 0, 0, 1);
        vt[13] = mk(0, 0, 1, 2, 0, S_MEAS,   1, 0, 1, 0, 0, 2);
        vt[14] = mk(0, 0, 1, 2, 0, S_MEAS,   1, 0, 1, 0, 0, 3);
        vt[15] = mk(0, 0, 1, 2, 0, S_MEAS,   1, 0, 1, 0, 0, 4);
        vt[16] = mk(0, 0, 1, 2, 0, S_DRAIN,  1, 0, 1, 0, 0, 5);
        vt[17] = mk(0, 0, 1, 2, 0, S_FROZEN, 0, 1, 0, 1, 0, 5);

        repeat (3) @(posedge clk);
        #1;
        chk_st("reset", S_IDLE, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk_st("reset_release", S_IDLE, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            cif.start     = vt[i].start;
            cif.abort     = vt[i].abort;
            cif.immediate = vt[i].immediate;
            cif.duration  = vt[i].duration;
            gmii_en       = vt[i].gmii_en;
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].es, vt[i].er, vt[i].ef, vt[i].eb, vt[i].ed, vt[i].ea, 0, vt[i].ee);
        end
        idle();

        cif.start = 1'b1; cif.immediate = 1'b1; cif.duration = 100; gmii_en = 1'b0;
        tick();
        idle();
        n = 0;
        while (cif.state == 3'd2 && n < 300) begin
            n++;
            tick();
        end
        chk_val("measure_len", n, 100);
        chk_st("drain_entry", S_DRAIN, 0, 0, 100);
        tick();
        chk_st("frozen_after_gap", S_FROZEN, 0, 0, 100);

        sec = 48'd5; nsec = 30'd999999950;
        cif.start = 1'b1; cif.immediate = 1'b0; cif.start_sec = 48'd5; cif.start_nsec = 30'd999999990; cif.duration = 1000;
        tick();
        idle();
        chk_st("wait_entry", S_WAIT, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            int ex;
            nsec = nsec + 30'd8;
            ex = (nsec >= 30'd999999990) ? S_MEAS : S_WAIT;
            tick();
            chk_st($sformatf("wait_ns%0d", nsec), ex, 0, 0, 0);
            if (ex == S_MEAS) break;
        end
        cif.abort = 1'b1;
        tick();
        idle();
        chk_st("abort_first_meas", S_IDLE, 1, 0, 0);

        cif.start = 1'b1; cif.immediate = 1'b1; cif.duration = 10; gmii_en = 1'b0;
        tick();
        idle();
        repeat (4) tick();
        gmii_en = 1'b1;
        n = 0;
        while (cif.state != 3'd3 && n < 50) begin
            n++;
            tick();
        end
        chk_st("gap_drain_entry", S_DRAIN, 0, 0, 10);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk_st("gap_hold", S_DRAIN, 0, 0, 10);
        end
        gmii_en = 1'b0;
        tick();
        chk_st("gap_frozen", S_FROZEN, 0, 0, 10);

        cif.start = 1'b1; cif.duration = 2; gmii_en = 1'b1;
        tick();
        idle();
        tick();
        tick();
        chk_st("tmo_drain_entry", S_DRAIN, 0, 0, 2);
        for (int k = 1; k < TMO; k++) begin
            tick();
            chk_st("tmo_hold", S_DRAIN, 0, 0, 2);
        end
        tick();
        chk_st("tmo_frozen", S_FROZEN, 0, 1, 2);
        gmii_en = 1'b0;

        cif.start = 1'b1; cif.duration = 100;
        tick();
        idle();
        chk_st("restart_clears_dto", S_MEAS, 0, 0, 0);
        n = 0;
        while (cif.elapsed != 37 && n < 100) begin
            n++;
            tick();
        end
        cif.abort = 1'b1; cif.start = 1'b1; cif.duration = 5;
        tick();
        idle();
        chk_st("abort_meas", S_IDLE, 1, 0, 37);
        tick();
        chk_st("abort_pulse_end", S_IDLE, 0, 0, 37);
        tick();
        cif.start = 1'b1; cif.duration = 100;
        tick();
        idle();
        chk_st("start_after_abort", S_MEAS, 0, 0, 0);

        cif.abort = 1'b1;
        tick();
        idle();
        cif.start = 1'b1; cif.duration = 0; gmii_en = 1'b1;
        tick();
        idle();
        chk_st("dur0_drain", S_DRAIN, 0, 0, 0);
        #2 resetn = 1'b0;
        #1 chk_st("async_reset", S_IDLE, 0, 0, 0);
        @(negedge clk);
        resetn = 1'b1;
        gmii_en = 1'b0;
        tick();
        chk_st("post_reset", S_IDLE, 0, 0, 0);

        m_state = S_IDLE; m_dn = 0; m_elapsed = '0; m_dur = '0; m_aborted = 1'b0; m_dt = 1'b0; m_t = '0;
        sec = 48'd1; nsec = '0;
        for (int i = 0; i < 2000; i++) begin
            logic          st, ab, im, g;
            logic [47:0]   ss;
            logic [29:0]   sn;
            logic [DW-1:0] du;
            int            r;
            st = ($urandom % 10) == 0;
            ab = ($urandom % 50) == 0;
            im = ($urandom % 2) == 0;
            g  = ($urandom % 4) != 0;
            r  = int'($urandom_range(0, 3));
            ss = (r == 0) ? 48'd0 : (r == 3) ? 48'd2 : 48'd1;
            sn = nsec + 30'($urandom_range(0, 160));
            du = DW'($urandom_range(0, 24));
            cif.start = st; cif.abort = ab; cif.immediate = im;
            cif.start_sec = ss; cif.start_nsec = sn; cif.duration = du;
            gmii_en = g;
            model_step(st, ab, im, ss, sn, du, g, {sec, nsec});
            tick();
            chk_st($sformatf("rand%0d", i), m_state, m_aborted, m_dt, m_elapsed);
            nsec = nsec + 30'd8;
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/traffic_analyzer_window_ctrl.md
Name: traffic_analyzer_window_ctrl

Overview:
Measurement-window sequencer for the GMII traffic analyzer. It drives the analyzer's `run` and `freeze_stats` control bits so that statistics cover a precisely bounded window. The window opens at a programmed absolute time (sec:nsec) or immediately, lasts a programmed number of clock cycles, and closes only on an inter-frame gap, so that no frame is split across the freeze. It sits between the CPU register block and the analyzer's control inputs, in the analyzer clock domain.

Parameters:
C_DURATION_WIDTH, 32, width of the window-length and elapsed counters.
C_DRAIN_TIMEOUT, 16384, maximum cycles to wait for gmii_en low after the window expires.
C_TIMEOUT_WIDTH, 15, width of the drain counter; must hold C_DRAIN_TIMEOUT.

Ports:
clk  in  1  analyzer clock; all logic is on its rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that arms a window
abort  in  1  single-cycle pulse that cancels the current window
immediate  in  1  when 1, skip the time wait; sampled on start
start_sec  in  48  window open time, seconds; sampled on start
start_nsec  in  30  window open time, nanoseconds (0..999999999); sampled on start
duration  in  C_DURATION_WIDTH  window length in clk cycles; sampled on start
sec  in  48  current time, seconds
nsec  in  30  current time, nanoseconds
gmii_en  in  1  GMII receive enable, used for gap detection
run  out  1  analyzer run bit
freeze_stats  out  1  analyzer freeze bit
busy  out  1  1 in WAIT_TIME, MEASURE and DRAIN
done  out  1  sticky; 1 in FROZEN
drain_timeout  out  1  sticky; set if DRAIN ended by timeout
aborted  out  1  one-cycle pulse when an abort is taken
state  out  3  encoded state for status readback
elapsed  out  C_DURATION_WIDTH  cycles spent in MEASURE for the current or last window

Behaviour:
- Reset (async assert, sync release): state=IDLE. run, freeze_stats, busy, done, drain_timeout, aborted and elapsed are all 0.
- Registers: all outputs are registered. Each output takes its value for the new state on the same edge that the state changes.
- State encoding: IDLE=0, WAIT_TIME=1, MEASURE=2, DRAIN=3, FROZEN=4.
- Output values by state (run, freeze_stats):
  - IDLE: 0, 0
  - WAIT_TIME: 0, 0
  - MEASURE: 1, 0
  - DRAIN: 1, 0
  - FROZEN: 0, 1
- IDLE or FROZEN, on start:
  - Latch immediate, start_sec, start_nsec and duration.
  - Clear done, drain_timeout and elapsed.
  - Go to MEASURE if immediate=1, otherwise to WAIT_TIME.
- start is ignored while busy=1.
- WAIT_TIME: the time compare is unsigned 78-bit, {sec,nsec} >= {start_sec,start_nsec}. When true, go to MEASURE on the next edge. A start time already in the past therefore enters MEASURE one cycle after WAIT_TIME.
- MEASURE:
  - elapsed increments by 1 each cycle.
  - When elapsed+1 == latched duration, go to DRAIN.
  - A latched duration of 0 goes straight from IDLE/WAIT_TIME to DRAIN with elapsed=0.
  - elapsed never exceeds duration and never wraps.
- DRAIN:
  - On entry, the drain counter is cleared.
  - If gmii_en=0, go to FROZEN on the next edge.
  - Otherwise the drain counter increments. When it reaches C_DRAIN_TIMEOUT-1, go to FROZEN and set drain_timeout.
  - gmii_en=0 in the first DRAIN cycle gives a one-cycle DRAIN.
- FROZEN: done=1 and freeze_stats=1 hold until start or abort.
- abort, in any state except IDLE:
  - Next state is IDLE and aborted pulses for one cycle.
  - run and freeze_stats go to 0; done and drain_timeout clear.
  - elapsed holds its value.
- abort in IDLE has no effect and no pulse.
- abort together with start: abort wins and start is dropped.
- Reset asserted mid-window forces IDLE with the outputs at their reset values, asynchronously.
- Time inputs are assumed stable in the clk domain; no synchronisers are included.

Test Plan:
- Reset release, then start with immediate=1, duration=100, gmii_en=0 → run rises one cycle after start and stays high 100 cycles in MEASURE; DRAIN lasts 1 cycle; then freeze_stats=1, done=1, elapsed=100, run=0.
- immediate=0, start_sec=5, start_nsec=999999990, with time stepping by 8 ns from 5:999999950 → stays in WAIT_TIME until nsec=999999990; MEASURE entered on the following edge.
- duration=10, gmii_en held 1 from cycle 5 of MEASURE for 200 cycles → DRAIN lasts until gmii_en falls; FROZEN entered on the next edge; drain_timeout=0.
- gmii_en stuck at 1 with C_DRAIN_TIMEOUT=16 → FROZEN exactly 16 cycles after DRAIN entry; drain_timeout=1.
- Abort issued in MEASURE at elapsed=37, with start asserted in the same cycle → IDLE, aborted pulses once, run=0, freeze_stats=0, elapsed=37; the next start, given 3 cycles later, is accepted.
- start issued in MEASURE → ignored, latched duration unchanged. duration=0 → DRAIN entered directly and elapsed=0. resetn pulsed low in DRAIN → run=0 immediately, before the next clk edge.
